// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
package fft_seq_pkg;

    localparam int FFT_N    = 512;
    localparam int HALF     = FFT_N / 2;
    // Magnitude helper works on sign-extended components up to this width
    localparam int MAG_IN_W = 32;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, READ, REPORT} state_t;

    // |re| + |im|, one bit wider than the inputs so -2^(w-1) is exact
    function automatic logic [MAG_IN_W:0] l1_mag(input logic signed [MAG_IN_W-1:0] re,
                                                 input logic signed [MAG_IN_W-1:0] im);
        logic signed [MAG_IN_W:0] re_x, im_x;
        logic [MAG_IN_W:0] re_abs, im_abs;
        re_x   = re;
        im_x   = im;
        re_abs = re_x[MAG_IN_W] ? -re_x : re_x;
        im_abs = im_x[MAG_IN_W] ? -im_x : im_x;
        return re_abs + im_abs;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Sample stream, fft_top control/load/readout and result signals.
interface fft_seq_if #(
    parameter int bit_width = 16,
    parameter int M         = 9
);
    logic                     run;
    logic                     sample_valid;
    logic [bit_width-1:0]     sample_in;
    logic                     sample_ready;
    logic                     fft_load;
    logic [M-1:0]             fft_adr;
    logic [2*bit_width-1:0]   fft_rd;
    logic                     fft_start;
    logic                     fft_done;
    logic [2*bit_width-1:0]   fft_wd;
    logic [M-1:0]             peak_bin;
    logic [bit_width:0]       peak_mag;
    logic                     result_valid;
    logic                     busy;
    logic                     timeout_err;

    // Sequencer side
    modport master (
        input  run, sample_valid, sample_in, fft_done, fft_wd,
        output sample_ready, fft_load, fft_adr, fft_rd, fft_start,
               peak_bin, peak_mag, result_valid, busy, timeout_err
    );

    // Environment side (front-end, fft_top, note detector)
    modport slave (
        output run, sample_valid, sample_in, fft_done, fft_wd,
        input  sample_ready, fft_load, fft_adr, fft_rd, fft_start,
               peak_bin, peak_mag, result_valid, busy, timeout_err
    );
endinterface

// File: rtl/fft_frame_sequencer_peak_tracker.sv
// Running maximum over a bin/magnitude stream; ties keep the earliest bin.
module peak_tracker #(
    parameter int M     = 9,
    parameter int MAG_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic [M-1:0]     bin,
    input  logic [MAG_W-1:0] mag,
    output logic [M-1:0]     max_bin,
    output logic [MAG_W-1:0] max_mag
);
    logic [M-1:0]     best_bin;
    logic [MAG_W-1:0] best_mag;

    // Winner including the current beat, so the caller can capture it on the last beat
    always_comb begin
        max_bin = best_bin;
        max_mag = best_mag;
        if (valid && (mag > best_mag)) begin
            max_bin = bin;
            max_mag = mag;
        end
    end

    // Hold the running winner
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            best_bin <= '0;
            best_mag <= '0;
        end else begin
            best_bin <= max_bin;
            best_mag <= max_mag;
        end
    end
endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects N samples into fft_top, starts it, reads back the lower half-spectrum
// and reports the peak-magnitude bin.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int bit_width = 16,
    parameter int M         = 9,
    parameter int N         = 512,
    parameter int TIMEOUT   = 65535
) (
    input logic       clk,
    input logic       reset,
    fft_seq_if.master bus
);
    localparam int half_n = N / 2;
    localparam int MAG_W  = bit_width + 1;

    state_t                      state, state_nxt;
    logic [M-1:0]                count, count_nxt;
    logic [M-1:0]                rd_cnt, rd_cnt_nxt;
    logic [31:0]                 wd, wd_nxt;
    logic                        set_timeout, capture;
    logic                        timeout_q;
    logic [M-1:0]                peak_bin_q;
    logic [MAG_W-1:0]            peak_mag_q;
    logic                        trk_clear, trk_valid;
    logic [M-1:0]                trk_bin, max_bin;
    logic [MAG_W-1:0]            wd_mag, max_mag;
    logic [bit_width-1:0]        wd_re, wd_im;

    assign wd_re  = bus.fft_wd[2*bit_width-1:bit_width];
    assign wd_im  = bus.fft_wd[bit_width-1:0];
    assign wd_mag = MAG_W'(l1_mag({{(MAG_IN_W-bit_width){wd_re[bit_width-1]}}, wd_re},
                                  {{(MAG_IN_W-bit_width){wd_im[bit_width-1]}}, wd_im}));

    peak_tracker #(.M(M), .MAG_W(MAG_W)) u_peak (
        .clk     (clk),
        .reset   (reset),
        .clear   (trk_clear),
        .valid   (trk_valid),
        .bin     (trk_bin),
        .mag     (wd_mag),
        .max_bin (max_bin),
        .max_mag (max_mag)
    );

    // Next state and per-cycle outputs; everything is held at 0 while reset is high
    always_comb begin
        state_nxt        = state;
        count_nxt        = count;
        rd_cnt_nxt       = rd_cnt;
        wd_nxt           = wd;
        set_timeout      = 1'b0;
        capture          = 1'b0;
        trk_clear        = 1'b0;
        trk_valid        = 1'b0;
        trk_bin          = rd_cnt - M'(1);
        bus.sample_ready = 1'b0;
        bus.fft_load     = 1'b0;
        bus.fft_adr      = '0;
        bus.fft_rd       = '0;
        bus.fft_start    = 1'b0;
        bus.result_valid = 1'b0;
        bus.busy         = 1'b0;
        if (!reset) begin
            bus.busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state_nxt = LOAD;
                        count_nxt = '0;
                    end
                end
                LOAD: begin
                    bus.sample_ready = 1'b1;
                    if (bus.sample_valid) begin
                        bus.fft_load = 1'b1;
                        bus.fft_adr  = count;
                        bus.fft_rd   = {bus.sample_in, {bit_width{1'b0}}};
                        count_nxt    = count + M'(1);
                        if (count == M'(N - 1)) state_nxt = START;
                    end
                end
                START: begin
                    bus.fft_start = 1'b1;
                    wd_nxt        = '0;
                    state_nxt     = WAIT;
                end
                WAIT: begin
                    if (bus.fft_done) begin
                        state_nxt  = READ;
                        rd_cnt_nxt = '0;
                        trk_clear  = 1'b1;
                    end else if (wd == 32'(TIMEOUT - 1)) begin
                        state_nxt   = IDLE;
                        set_timeout = 1'b1;
                    end else begin
                        wd_nxt = wd + 32'd1;
                    end
                end
                READ: begin
                    // fft_wd lags fft_adr by one cycle, so the tracker sees bin rd_cnt-1;
                    // bins 0 (DC) is skipped and the last count is a drain-only cycle
                    trk_valid  = (rd_cnt >= M'(2));
                    rd_cnt_nxt = rd_cnt + M'(1);
                    if (rd_cnt == M'(half_n)) begin
                        capture   = 1'b1;
                        state_nxt = REPORT;
                    end else begin
                        bus.fft_adr = rd_cnt;
                    end
                end
                REPORT: begin
                    bus.result_valid = 1'b1;
                    if (bus.run) begin
                        state_nxt = LOAD;
                        count_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, counters and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            rd_cnt     <= '0;
            wd         <= '0;
            timeout_q  <= 1'b0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            rd_cnt <= rd_cnt_nxt;
            wd     <= wd_nxt;
            if (set_timeout) timeout_q <= 1'b1;
            if (capture) begin
                peak_bin_q <= max_bin;
                peak_mag_q <= max_mag;
            end
        end
    end

    assign bus.peak_bin    = reset ? '0 : peak_bin_q;
    assign bus.peak_mag    = reset ? '0 : peak_mag_q;
    assign bus.timeout_err = reset ? 1'b0 : timeout_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed and randomized frames against a stub fft_top and a peak-search model.
module tb_fft_frame_sequencer;
    localparam int BW   = 16;
    localparam int M    = 9;
    localparam int N    = 512;
    localparam int TO   = 200;
    localparam int HALF = fft_seq_pkg::HALF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          errors = 0;
    int          checks = 0;
    bit          never_done = 1'b0;
    int          done_cnt;
    logic [31:0] spec_mem [N];
    logic [31:0] loaded [N];

    fft_seq_if #(.bit_width(BW), .M(M)) bus ();

    fft_frame_sequencer #(.bit_width(BW), .M(M), .N(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stub fft_top: stores loads, raises done ~100 cycles after start, returns spectrum
    always @(posedge clk) begin
        if (reset) begin
            bus.fft_done <= 1'b0;
            done_cnt     <= 0;
        end else begin
            if (bus.fft_load) loaded[bus.fft_adr] <= bus.fft_rd;
            if (bus.fft_start) begin
                bus.fft_done <= 1'b0;
                done_cnt     <= 100;
            end else if (done_cnt == 1) begin
                done_cnt <= 0;
                if (!never_done) bus.fft_done <= 1'b1;
            end else if (done_cnt > 1) begin
                done_cnt <= done_cnt - 1;
            end
        end
        bus.fft_wd <= spec_mem[bus.fft_adr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string p);
        check({p, "_load"}, bus.fft_load, 0);
        check({p, "_start"}, bus.fft_start, 0);
        check({p, "_ready"}, bus.sample_ready, 0);
        check({p, "_rvalid"}, bus.result_valid, 0);
        check({p, "_busy"}, bus.busy, 0);
        check({p, "_toerr"}, bus.timeout_err, 0);
        check({p, "_pbin"}, bus.peak_bin, 0);
        check({p, "_pmag"}, bus.peak_mag, 0);
        check({p, "_adr"}, bus.fft_adr, 0);
        check({p, "_rd"}, bus.fft_rd, 0);
    endtask

    // Reference: strict-greater L1 search over bins 1..HALF-1
    task automatic ref_peak(output int rb, output int rm);
        int re, im, m;
        rb = 0;
        rm = 0;
        for (int b = 1; b < HALF; b++) begin
            re = int'($signed(spec_mem[b][31:16]));
            im = int'($signed(spec_mem[b][15:0]));
            m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
            if (m > rm) begin
                rb = b;
                rm = m;
            end
        end
    endtask

    task automatic load_phase(input int n, input bit from_idle, input int drop_at,
                              input bit toggle, input bit ramp);
        int         acc = 0;
        int         cyc = 0;
        bit         exp_ready;
        bit         v;
        logic [15:0] s;
        exp_ready = !from_idle;
        while (acc < n) begin
            if (cyc > 4000) begin
                check("load_budget", acc, n);
                finish_run();
            end
            v = toggle ? cyc[0] : ($urandom_range(0, 3) != 0);
            s = ramp ? 16'(acc) : 16'($urandom);
            bus.sample_valid = v;
            bus.sample_in    = s;
            #1;
            check("sample_ready", bus.sample_ready, exp_ready);
            check("fft_load", bus.fft_load, v && exp_ready);
            check("no_start_in_load", bus.fft_start, 0);
            if (v && exp_ready) begin
                check("load_adr", bus.fft_adr, acc);
                check("load_rd", bus.fft_rd, {s, 16'h0000});
                acc++;
                if (acc == drop_at) bus.run = 1'b0;
            end
            tick();
            cyc++;
            exp_ready = 1'b1;
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic back_end(input bit to_mode, input bit run_at_report,
                            input int exp_bin, input int exp_mag);
        int extra_start = 0;
        int extra_rv    = 0;
        bit seen        = 1'b0;
        #1;
        check("start_pulse", bus.fft_start, 1);
        check("start_no_load", bus.fft_load, 0);
        check("start_not_ready", bus.sample_ready, 0);
        if (to_mode) begin
            for (int c = 1; c <= TO + 1; c++) begin
                tick();
                if (bus.result_valid) extra_rv++;
                if (bus.fft_start) extra_start++;
                if (c == TO) begin
                    check("to_not_yet", bus.timeout_err, 0);
                    check("to_busy_in_wait", bus.busy, 1);
                end
            end
            check("timeout_err", bus.timeout_err, 1);
            check("to_idle", bus.busy, 0);
            for (int c = 0; c < 5; c++) begin
                tick();
                if (bus.result_valid) extra_rv++;
            end
            check("to_sticky", bus.timeout_err, 1);
            check("to_no_result", extra_rv, 0);
            check("to_one_start", extra_start, 0);
            return;
        end
        for (int k = 1; k <= 1000 && !seen; k++) begin
            tick();
            if (bus.result_valid) extra_rv++;
            if (bus.fft_start) extra_start++;
            if (bus.fft_done) seen = 1'b1;
        end
        check("wait_done_seen", seen, 1);
        check("wait_one_start", extra_start, 0);
        check("wait_no_result", extra_rv, 0);
        for (int j = 0; j <= HALF; j++) begin
            tick();
            check("read_adr", bus.fft_adr, (j < HALF) ? j : 0);
            check("read_no_result", bus.result_valid, 0);
        end
        tick();
        check("result_valid", bus.result_valid, 1);
        check("peak_bin", bus.peak_bin, exp_bin);
        check("peak_mag", bus.peak_mag, exp_mag);
        tick();
        check("result_one_cycle", bus.result_valid, 0);
        check("peak_bin_hold", bus.peak_bin, exp_bin);
        check("peak_mag_hold", bus.peak_mag, exp_mag);
        check("after_report_ready", bus.sample_ready, run_at_report);
        check("after_report_busy", bus.busy, run_at_report);
    endtask

    initial begin
        #1000000;
        errors++;
        $error("FAIL global_time_limit observed=expired expected=finished");
        finish_run();
    end

    initial begin
        int rb, rm;
        bus.run          = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        for (int b = 0; b < N; b++) spec_mem[b] = '0;

        // Reset values
        reset = 1'b1;
        tick(); tick(); tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check("idle_busy", bus.busy, 0);
        check("idle_ready", bus.sample_ready, 0);

        // Ramp load with gapped valid; single peak at bin 37; run dropped mid-load
        spec_mem[37] = {16'h0100, 16'hFF00};
        bus.run = 1'b1;
        load_phase(N, 1'b1, 10, 1'b1, 1'b1);
        back_end(1'b0, 1'b0, 37, 'h200);
        check("stub_loaded_last", loaded[N-1], {16'(N - 1), 16'h0000});

        // Three back-to-back frames
        for (int b = 0; b < N; b++)
            spec_mem[b] = {16'($urandom_range(0, 'h6000) - 'h3000), 16'($urandom_range(0, 'h6000) - 'h3000)};
        spec_mem[0]  = {16'h7FFF, 16'h0000};
        spec_mem[12] = {16'h7FFF, 16'h0000};
        spec_mem[40] = {16'h7FFF, 16'h0000};
        bus.run = 1'b1;
        load_phase(N, 1'b1, -1, 1'b0, 1'b0);
        back_end(1'b0, 1'b1, 12, 'h7FFF);

        for (int b = 0; b < N; b++) spec_mem[b] = $urandom;
        spec_mem[200] = 32'h8000_8000;
        ref_peak(rb, rm);
        load_phase(N, 1'b0, -1, 1'b0, 1'b0);
        back_end(1'b0, 1'b1, rb, rm);
        check("most_negative_mag", bus.peak_mag, 'h10000);

        for (int b = 0; b < N; b++) spec_mem[b] = '0;
        spec_mem[0] = 32'h1234_5678;
        load_phase(N, 1'b0, 5, 1'b0, 1'b0);
        back_end(1'b0, 1'b0, 0, 0);

        // Watchdog expiry with done never raised
        never_done = 1'b1;
        bus.run = 1'b1;
        load_phase(N, 1'b1, 3, 1'b0, 1'b0);
        back_end(1'b1, 1'b0, 0, 0);
        never_done = 1'b0;

        // Reset in the middle of a load, then a complete fresh frame
        bus.run = 1'b1;
        load_phase(100, 1'b1, -1, 1'b0, 1'b0);
        reset = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'h5A5A;
        #1;
        check_zero("rst_mid");
        tick();
        check_zero("rst_edge");
        tick();
        reset = 1'b0;
        bus.sample_valid = 1'b0;
        #1;
        check("rst_clears_timeout", bus.timeout_err, 0);
        for (int b = 0; b < N; b++) spec_mem[b] = $urandom;
        ref_peak(rb, rm);
        load_phase(N, 1'b1, 50, 1'b0, 1'b0);
        back_end(1'b0, 1'b0, rb, rm);

        finish_run();
    end
endmodule
